// File: rtl/mem_access_ctrl.sv
// MEM-stage bus sequencer: issues the EX/MEM pair (A then B) on the single data bus.
// Define MEM_BUS_TIMEOUT_EN to build the bus watchdog (TIMEOUT_CYCLES, bus_err).
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a_ce,
  input  logic        req_a_we,
  input  logic [31:0] req_a_addr,
  input  logic [31:0] req_a_wdata,
  input  logic [1:0]  req_a_size,
  input  logic        req_a_uns,
  input  logic        req_b_ce,
  input  logic        req_b_we,
  input  logic [31:0] req_b_addr,
  input  logic [31:0] req_b_wdata,
  input  logic [1:0]  req_b_size,
  input  logic        req_b_uns,
  input  logic        flush,
  input  logic        hold,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic        bus_err
);
  // state | meaning
  // IDLE  | waiting for a pair from EX/MEM
  // ACC_A | pipe A transfer on the bus
  // ACC_B | pipe B transfer on the bus
  // DONE  | pair complete, load results valid
  // DRAIN | flushed; waiting for the already-issued transfer to ack
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACC_A = 3'd1;
  localparam logic [2:0] S_ACC_B = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nx;
  logic        w_pair;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata_a;
  logic [31:0] r_rdata_b;

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    f_be = 4'b0001 << lo;
      2'd1:    f_be = 4'b0011 << {lo[1], 1'b0};
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'd0:    f_wdata = {4{wd[7:0]}};
      2'd1:    f_wdata = {2{wd[15:0]}};
      default: f_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] size, input logic uns,
                                         input logic [1:0] lo, input logic [31:0] rd);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    case (lo)
      2'd0:    v_b = rd[7:0];
      2'd1:    v_b = rd[15:8];
      2'd2:    v_b = rd[23:16];
      default: v_b = rd[31:24];
    endcase
    v_h = lo[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'd0:    f_load = uns ? {24'd0, v_b} : {{24{v_b[7]}}, v_b};
      2'd1:    f_load = uns ? {16'd0, v_h} : {{16{v_h[15]}}, v_h};
      default: f_load = rd;
    endcase
  endfunction

  assign w_pair = req_a_ce | req_b_ce;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_bus_err;
  logic             w_timeout;

  // The watchdog completes the stuck access as if the bus had returned zero.
  assign w_timeout = r_bus_req && !bus_ack && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_ack     = bus_ack | w_timeout;
  assign w_rdata   = w_timeout ? 32'd0 : bus_rdata;
  assign bus_err   = r_bus_err;

  always_ff @(posedge clk) begin
    if (rst || bus_ack || (w_state_nx != r_state)) begin
      r_to_cnt <= '0;
    end else if (r_bus_req) begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
    if (rst) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
    end
  end
`else
  assign w_ack   = bus_ack;
  assign w_rdata = bus_rdata;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (!flush && w_pair) w_state_nx = req_a_ce ? S_ACC_A : S_ACC_B;
      end
      S_ACC_A: begin
        if (w_ack)      w_state_nx = flush ? S_IDLE : (req_b_ce ? S_ACC_B : S_DONE);
        else if (flush) w_state_nx = S_DRAIN;
      end
      S_ACC_B: begin
        if (w_ack)      w_state_nx = flush ? S_IDLE : S_DONE;
        else if (flush) w_state_nx = S_DRAIN;
      end
      S_DONE: begin
        if (flush || !hold) w_state_nx = S_IDLE;
      end
      S_DRAIN: begin
        if (w_ack) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_rdata_a   <= 32'd0;
      r_rdata_b   <= 32'd0;
    end else begin
      r_state   <= w_state_nx;
      r_bus_req <= (w_state_nx == S_ACC_A) || (w_state_nx == S_ACC_B) ||
                   (w_state_nx == S_DRAIN);
      // Bus fields load only on entry to an access so they stay stable until ack.
      if ((w_state_nx == S_ACC_A) && (r_state != S_ACC_A)) begin
        r_bus_we    <= req_a_we;
        r_bus_addr  <= {req_a_addr[31:2], 2'b00};
        r_bus_be    <= f_be(req_a_size, req_a_addr[1:0]);
        r_bus_wdata <= f_wdata(req_a_size, req_a_wdata);
      end else if ((w_state_nx == S_ACC_B) && (r_state != S_ACC_B)) begin
        r_bus_we    <= req_b_we;
        r_bus_addr  <= {req_b_addr[31:2], 2'b00};
        r_bus_be    <= f_be(req_b_size, req_b_addr[1:0]);
        r_bus_wdata <= f_wdata(req_b_size, req_b_wdata);
      end
      if ((r_state == S_ACC_A) && w_ack && !flush && !req_a_we) begin
        r_rdata_a <= f_load(req_a_size, req_a_uns, req_a_addr[1:0], w_rdata);
      end
      if ((r_state == S_ACC_B) && w_ack && !flush && !req_b_we) begin
        r_rdata_b <= f_load(req_b_size, req_b_uns, req_b_addr[1:0], w_rdata);
      end
    end
  end

  assign stall_req = w_pair && (r_state != S_DONE);
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;
  assign rdata_a   = r_rdata_a;
  assign rdata_b   = r_rdata_b;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage data-bus sequencer for the dual-issue pipeline. It consumes the two memory requests held in the EX/MEM register (pipe A, pipe B) and serialises them onto the single data bus, A first. It aligns store data and byte enables and extracts and extends load data. It raises a stall request to the stall controller until both accesses of the pair complete.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: bus watchdog limit. Used only with MEM_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_a_ce / req_b_ce  in  1  access valid, pipe A / B
- req_a_we / req_b_we  in  1  1 = store, 0 = load
- req_a_addr / req_b_addr  in  32  byte address
- req_a_wdata / req_b_wdata  in  32  store data, right-justified
- req_a_size / req_b_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- req_a_uns / req_b_uns  in  1  zero-extend load when 1
- flush  in  1  pipeline flush
- hold  in  1  downstream stall; keep results and stay in DONE
- stall_req  out  1  MEM stage busy
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  word address {addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transfer complete this cycle
- bus_rdata  in  32  read data, valid with bus_ack
- rdata_a / rdata_b  out  32  extended load result
- bus_err  out  1  watchdog fired; always 0 without MEM_BUS_TIMEOUT_EN

## Operation
- States: IDLE, ACC_A, ACC_B, DONE, DRAIN.
- IDLE, rising edge, no flush, a pair is present (req_a_ce | req_b_ce): go to ACC_A if req_a_ce is set, else ACC_B.
- ACC_A on bus_ack:
  - go to ACC_B if req_b_ce is set, else DONE;
  - latch rdata_a if the access is a load.
- ACC_B on bus_ack: latch rdata_b if a load; go to DONE.
- DONE: go to IDLE when hold=0; stay in DONE while hold=1.
- stall_req = pair present and state ∈ {IDLE, ACC_A, ACC_B, DRAIN}. It is 0 in DONE and 0 when neither ce is set.
- Byte enables:
  - byte: 4'b0001 << addr[1:0];
  - half: 4'b0011 << {addr[1], 1'b0};
  - word: 4'b1111.
- Store data:
  - byte: wdata[7:0] replicated ×4;
  - half: wdata[15:0] replicated ×2;
  - word: wdata as is.
- Load data:
  - select the lane(s) given by addr[1:0];
  - sign-extend, or zero-extend when uns=1.
- Misalignment is detected upstream. Low address bits beyond the access size are ignored here.
- A store leaves its rdata register unchanged.
- Flush:
  - In IDLE or DONE: go to IDLE.
  - In ACC_A or ACC_B: an issued transfer cannot be aborted. Go to DRAIN, which keeps bus_req and the bus fields stable until bus_ack, then goes to IDLE. Drained read data is discarded.
- Reset mid-access: go to IDLE immediately and drop bus_req; the bus owner tolerates the abandoned request.

## Timing
- Reset values: state IDLE; bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, rdata_a 0, rdata_b 0, bus_err 0. stall_req is 0 because no pair is present after the EX/MEM reset.
- Bus outputs are registered.
  - bus_req rises 1 cycle after the pair appears.
  - Address, be, we and wdata are held stable while bus_req=1 and no ack.
  - bus_ack may arrive in the first cycle of bus_req.
- Back-to-back accesses: B's bus_req is asserted in the cycle after A's ack; there is no idle gap.
- Minimum pair latency with zero-wait ack:
  - single access: 3 cycles (IDLE→ACC→DONE);
  - A+B: 4 cycles.
- rdata_a/rdata_b are valid from the first DONE cycle and held until the next latch.

## Configuration
- MEM_BUS_TIMEOUT_EN defined:
  - An 8+ bit counter counts cycles with bus_req=1 and no bus_ack.
  - When it reaches TIMEOUT_CYCLES: the current access completes as if acked with read data 0; bus_err pulses for one cycle; the counter clears.
  - The counter clears on every ack and on every state change.
- Not defined: no counter is built, bus_err is tied to 0, and the stage waits on the bus indefinitely.

## Test plan
- A: word load from 0x1000, B idle; bus returns 0xDEADBEEF with 2 wait cycles → one bus_req with bus_be=1111; rdata_a=0xDEADBEEF; stall_req high for 4 cycles.
- A: store byte 0x5A to 0x2003; B: signed byte load from 0x2001 returning 0x00FF8000 → first transfer bus_be=1000, bus_wdata=0x5A5A5A5A; second bus_be=0010; rdata_b=0xFFFFFF80.
- Unsigned half load from 0x3002, bus returns 0xABCD1234 → bus_be=1100, rdata_a=0x0000ABCD.
- Flush in ACC_A with ack 3 cycles later → bus_req held until ack, then IDLE; rdata unchanged; B is never issued.
- hold=1 for 2 cycles while in DONE → state stays DONE; stall_req=0; rdata stable; no new bus_req.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus never acks → bus_err pulses after 4 bus_req cycles; rdata_a=0; next access proceeds. Without the macro → still waiting after 1000 cycles.
